// File: rtl/inst_fifo_pkg.sv
// Shared CPU package: instruction-queue depth and the entry layout.
`timescale 1ns/1ps
package inst_fifo_pkg;

  localparam int FIFO_DEPTH = 16;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fifo_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Dual-issue instruction queue: up to two pushes from fetch and up to two
// pops to the master/slave decoders per cycle, with a synchronous flush.
`timescale 1ns/1ps
module inst_fifo
  import inst_fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_flush,
  input  logic        write_en1,
  input  logic        write_en2,
  input  logic [31:0] write_inst1,
  input  logic [31:0] write_inst2,
  input  logic [31:0] write_pc1,
  input  logic [31:0] write_pc2,
  input  logic        read_en1,
  input  logic        read_en2,
  output logic [31:0] read_inst1,
  output logic [31:0] read_pc1,
  output logic [31:0] read_inst2,
  output logic [31:0] read_pc2,
  output logic        fifo_empty,
  output logic        fifo_almost_empty,
  output logic        fifo_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  fifo_entry_t   mem_q [DEPTH];
  fifo_entry_t   mem_d [DEPTH];

  logic [1:0]    push_req, push_cnt, pop_cnt;
  logic [CW-1:0] space_free;
  logic [PW-1:0] wptr_p1, rptr_p1;

  assign wptr_p1    = wptr_q + PW'(1);
  assign rptr_p1    = rptr_q + PW'(1);
  assign space_free = CW'(DEPTH) - count_q;

  // Push/pop counts; pushes beyond the free space seen at the start of the
  // cycle are dropped, so count can never exceed DEPTH.
  always_comb begin
    push_req = 2'd0;
    if (write_en1) push_req = write_en2 ? 2'd2 : 2'd1;
    push_cnt = (CW'(push_req) > space_free) ? space_free[1:0] : push_req;
    pop_cnt = 2'd0;
    if (read_en1 && count_q != '0)
      pop_cnt = (read_en2 && count_q >= CW'(2)) ? 2'd2 : 2'd1;
  end

  // Next-state for pointers, count and entry array; flush wins over all.
  always_comb begin
    mem_d = mem_q;
    if (push_cnt != 2'd0) mem_d[wptr_q]  = '{inst: write_inst1, pc: write_pc1};
    if (push_cnt == 2'd2) mem_d[wptr_p1] = '{inst: write_inst2, pc: write_pc2};
    wptr_d  = wptr_q + PW'(push_cnt);
    rptr_d  = rptr_q + PW'(pop_cnt);
    count_d = count_q + CW'(push_cnt) - CW'(pop_cnt);
    if (fifo_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  // Pointer and occupancy registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: outputs are gated by count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Head and head+1 views; zero when the slot holds no valid entry.
  always_comb begin
    read_inst1 = '0;
    read_pc1   = '0;
    read_inst2 = '0;
    read_pc2   = '0;
    if (count_q >= CW'(1)) begin
      read_inst1 = mem_q[rptr_q].inst;
      read_pc1   = mem_q[rptr_q].pc;
    end
    if (count_q >= CW'(2)) begin
      read_inst2 = mem_q[rptr_p1].inst;
      read_pc2   = mem_q[rptr_p1].pc;
    end
  end

  assign fifo_empty        = (count_q == '0);
  assign fifo_almost_empty = (count_q == CW'(1));
  assign fifo_full         = (count_q >= CW'(DEPTH - 1));

  // Fetch must never push more than the queue can hold.
  push_overflow_chk: assert property (@(posedge clk) disable iff (rst)
    fifo_flush || (CW'(push_req) <= space_free));

endmodule

// File: tb/tb_inst_fifo.sv
// Directed bench for inst_fifo with a queue-based reference model.
`timescale 1ns/1ps
module tb_inst_fifo;

  localparam int DEPTH = 16;

  logic        clk, rst, fifo_flush;
  logic        write_en1, write_en2, read_en1, read_en2;
  logic [31:0] write_inst1, write_inst2, write_pc1, write_pc2;
  logic [31:0] read_inst1, read_pc1, read_inst2, read_pc2;
  logic        fifo_empty, fifo_almost_empty, fifo_full;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] mq[$];
  int          m_wptr, m_rptr;

  inst_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .fifo_flush(fifo_flush),
    .write_en1(write_en1), .write_en2(write_en2),
    .write_inst1(write_inst1), .write_inst2(write_inst2),
    .write_pc1(write_pc1), .write_pc2(write_pc2),
    .read_en1(read_en1), .read_en2(read_en2),
    .read_inst1(read_inst1), .read_pc1(read_pc1),
    .read_inst2(read_inst2), .read_pc2(read_pc2),
    .fifo_empty(fifo_empty), .fifo_almost_empty(fifo_almost_empty),
    .fifo_full(fifo_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue in push order plus modulo pointers.
  task automatic model_step();
    int pop, req, acc, space;
    if (fifo_flush) begin
      mq.delete();
      m_wptr = 0;
      m_rptr = 0;
      return;
    end
    pop = 0;
    if (read_en1 && mq.size() > 0) pop = (read_en2 && mq.size() >= 2) ? 2 : 1;
    req   = write_en1 ? (write_en2 ? 2 : 1) : 0;
    space = DEPTH - mq.size();
    acc   = (req > space) ? space : req;
    for (int i = 0; i < pop; i++) void'(mq.pop_front());
    if (acc >= 1) mq.push_back({write_inst1, write_pc1});
    if (acc == 2) mq.push_back({write_inst2, write_pc2});
    m_rptr = (m_rptr + pop) % DEPTH;
    m_wptr = (m_wptr + acc) % DEPTH;
  endtask

  // Drive one cycle, advance the model on the edge, settle 1ns past it.
  task automatic cyc(input logic we1, input logic we2, input logic [31:0] pc1,
                     input logic [31:0] pc2, input logic re1, input logic re2,
                     input logic fl);
    write_en1 = we1; write_en2 = we2;
    write_pc1 = pc1; write_pc2 = pc2;
    write_inst1 = inst_of(pc1); write_inst2 = inst_of(pc2);
    read_en1 = re1; read_en2 = re2; fifo_flush = fl;
    @(posedge clk);
    model_step();
    #1;
    write_en1 = 1'b0; write_en2 = 1'b0; read_en1 = 1'b0; read_en2 = 1'b0;
    fifo_flush = 1'b0;
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      logic [63:0] e1, e2;
      e1 = (mq.size() >= 1) ? mq[0] : 64'd0;
      e2 = (mq.size() >= 2) ? mq[1] : 64'd0;
      chk("cmp_inst1", read_inst1, e1[63:32]);
      chk("cmp_pc1",   read_pc1,   e1[31:0]);
      chk("cmp_inst2", read_inst2, e2[63:32]);
      chk("cmp_pc2",   read_pc2,   e2[31:0]);
      chk("cmp_empty", 32'(fifo_empty), 32'(mq.size() == 0));
      chk("cmp_almost_empty", 32'(fifo_almost_empty), 32'(mq.size() == 1));
      chk("cmp_full",  32'(fifo_full), 32'(mq.size() >= DEPTH - 1));
      chk("cmp_count", 32'(dut.count_q), 32'(mq.size()));
    end
  end

  initial begin
    rst = 1'b1; fifo_flush = 1'b0;
    write_en1 = 1'b0; write_en2 = 1'b0; read_en1 = 1'b0; read_en2 = 1'b0;
    write_pc1 = '0; write_pc2 = '0; write_inst1 = '0; write_inst2 = '0;
    m_wptr = 0; m_rptr = 0;
    #12;
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_almost_empty", 32'(fifo_almost_empty), 32'd0);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_pc1", read_pc1, 32'd0);
    rst = 1'b0;

    // Dual push after reset.
    cyc(1, 1, 32'h1000, 32'h1004, 0, 0, 0);
    chk("dual_push_pc1", read_pc1, 32'h1000);
    chk("dual_push_pc2", read_pc2, 32'h1004);
    chk("dual_push_inst1", read_inst1, 32'hC0DE_1000);
    chk("dual_push_empty", 32'(fifo_empty), 32'd0);
    chk("dual_push_almost", 32'(fifo_almost_empty), 32'd0);

    // Single pop, then a dual-pop request with one entry left.
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("one_left_almost", 32'(fifo_almost_empty), 32'd1);
    chk("one_left_pc1", read_pc1, 32'h1004);
    chk("one_left_pc2", read_pc2, 32'd0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    chk("pop2_at_1_empty", 32'(fifo_empty), 32'd1);
    chk("pop2_at_1_pc1", read_pc1, 32'd0);

    // Write_en2 alone is ignored.
    cyc(0, 1, 32'h5000, 32'h5004, 0, 0, 0);
    chk("we2_alone_empty", 32'(fifo_empty), 32'd1);

    // Fill to 15 entries, then pop one.
    for (int i = 0; i < 7; i++)
      cyc(1, 1, 32'h4000 + 32'(i * 8), 32'h4004 + 32'(i * 8), 0, 0, 0);
    chk("fill14_full", 32'(fifo_full), 32'd0);
    cyc(1, 0, 32'h4100, 0, 0, 0, 0);
    chk("fill15_full", 32'(fifo_full), 32'd1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("pop_from_full", 32'(fifo_full), 32'd0);
    chk("pop_from_full_pc1", read_pc1, 32'h4004);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 1, 1, 0);
    chk("drained_empty", 32'(fifo_empty), 32'd1);

    // Walk both pointers to 15 with concurrent push/pop, then wrap a pair.
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++)
      cyc(1, 1, 32'h6000 + 32'(i * 8), 32'h6004 + 32'(i * 8), 1, 1, 0);
    cyc(1, 0, 32'h6100, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("wrap_wptr", 32'(dut.wptr_q), 32'd15);
    chk("wrap_rptr", 32'(dut.rptr_q), 32'd15);
    cyc(1, 1, 32'h2000, 32'h2004, 0, 0, 0);
    chk("wrap_pc1", read_pc1, 32'h2000);
    chk("wrap_pc2", read_pc2, 32'h2004);
    chk("wrap_wptr_after", 32'(dut.wptr_q), 32'd1);
    cyc(0, 0, 0, 0, 1, 1, 0);
    chk("wrap_pop_empty", 32'(fifo_empty), 32'd1);

    // Flush overrides simultaneous push and pop.
    cyc(1, 1, 32'h7000, 32'h7004, 0, 0, 0);
    cyc(1, 1, 32'h7008, 32'h700C, 0, 0, 0);
    cyc(1, 1, 32'h7010, 32'h7014, 1, 1, 1);
    chk("flush_empty", 32'(fifo_empty), 32'd1);
    chk("flush_count", 32'(dut.count_q), 32'd0);
    chk("flush_wptr", 32'(dut.wptr_q), 32'd0);
    chk("flush_rptr", 32'(dut.rptr_q), 32'd0);

    // Asynchronous reset mid-cycle at six entries.
    for (int i = 0; i < 3; i++)
      cyc(1, 1, 32'h8000 + 32'(i * 8), 32'h8004 + 32'(i * 8), 0, 0, 0);
    #2 rst = 1'b1;
    mq.delete(); m_wptr = 0; m_rptr = 0;
    #1;
    chk("arst_empty", 32'(fifo_empty), 32'd1);
    chk("arst_almost", 32'(fifo_almost_empty), 32'd0);
    chk("arst_full", 32'(fifo_full), 32'd0);
    chk("arst_pc1", read_pc1, 32'd0);
    chk("arst_inst2", read_inst2, 32'd0);
    rst = 1'b0;
    cyc(1, 0, 32'h3000, 0, 0, 0, 0);
    chk("arst_push_idx0", dut.mem_q[0].pc, 32'h3000);
    chk("arst_push_pc1", read_pc1, 32'h3000);
    chk("arst_wptr", 32'(dut.wptr_q), 32'd1);

    // Mixed traffic that respects the fetch contract.
    for (int i = 0; i < 40; i++) begin
      logic we1, we2;
      we1 = 1'($urandom_range(1));
      we2 = 1'($urandom_range(1));
      if (mq.size() > DEPTH - 2) we1 = 1'b0;
      cyc(we1, we2, $urandom, $urandom, 1'($urandom_range(1)),
          1'($urandom_range(1)), ($urandom_range(15) == 0));
    end
    chk("mix_wptr", 32'(dut.wptr_q), 32'(m_wptr));
    chk("mix_rptr", 32'(dut.rptr_q), 32'(m_rptr));

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
